// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver (LSB first) feeding a small first-word-fall-through FIFO,
// with sticky framing/overrun error flags.
// Optional build macro UART_RX_PARITY_EN adds one even-parity bit between data and stop;
// without it parity_err is tied low.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 87,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  input  logic       rd_en,
  input  logic       clr_err,
  output logic [7:0] rd_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF_CNT  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  logic [1:0]    sync_q, sync_d;
  logic          rxd_s;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          push, frame_set;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic          pop, full, wr_en, ovr_set;
  logic          frame_err_q, frame_err_d, overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
  logic          par_bad_q, par_bad_d, par_set;
  logic          par_err_q, par_err_d;
`endif

  // Two-flop synchronizer; the raw pin is never sampled directly.
  assign sync_d = {sync_q[0], rxd};
  assign rxd_s  = sync_q[1];

  // Receive FSM: start-bit qualification at mid-bit, then one sample per bit period.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    push      = 1'b0;
    frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    par_set   = 1'b0;
`endif
    case (state_q)
      S_IDLE: if (!rxd_s) begin
        state_d = S_START;
        cnt_d   = '0;
      end
      S_START: if (cnt_q == HALF_CNT) begin
        if (!rxd_s) begin
          state_d = S_DATA;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          state_d = S_IDLE;  // line bounced high: not a real start bit
        end
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      S_DATA: if (cnt_q == FULL_CNT) begin
        shift_d[bit_q] = rxd_s;
        cnt_d          = '0;
        bit_d          = bit_q + 3'd1;
        if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: if (cnt_q == FULL_CNT) begin
        par_bad_d = rxd_s ^ (^shift_q);  // even parity: data bits plus parity bit XOR to 0
        par_set   = par_bad_d;
        cnt_d     = '0;
        state_d   = S_STOP;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
`endif
      S_STOP: if (cnt_q == FULL_CNT) begin
        state_d = S_IDLE;  // back to idle at mid-stop-bit so the next start edge is not missed
        if (rxd_s) begin
`ifdef UART_RX_PARITY_EN
          push = ~par_bad_q;
`else
          push = 1'b1;
`endif
        end else begin
          frame_set = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO control: a simultaneous pop frees the slot a push into a full FIFO needs.
  always_comb begin
    pop      = rd_en && (count_q != '0);
    full     = (count_q == DEPTH_CNT);
    wr_en    = push && (!full || pop);
    ovr_set  = push && full && !pop;
    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (wr_en && !pop)      count_d = count_q + (AW + 1)'(1);
    else if (!wr_en && pop) count_d = count_q - (AW + 1)'(1);
  end

  // Sticky error flags: a new event in the clearing cycle wins.
  always_comb begin
    frame_err_d = frame_set | (frame_err_q & ~clr_err);
    overrun_d   = ovr_set | (overrun_q & ~clr_err);
`ifdef UART_RX_PARITY_EN
    par_err_d   = par_set | (par_err_q & ~clr_err);
`endif
  end

  // State, pointer and flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q      <= 2'b11;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q   <= 1'b0;
      par_err_q   <= 1'b0;
`endif
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q   <= par_bad_d;
      par_err_q   <= par_err_d;
`endif
    end
  end

  // Storage needs no reset: the read port is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= shift_q;
  end

  assign rx_valid  = (count_q != '0);
  assign rd_data   = rx_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = par_err_q;
`else
  assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: serial frames driven bit by bit, a queue-based FIFO model
// plus sticky-flag model, and a monitor that checks every byte the DUT hands out.
module tb_uart_rx_fifo;
  localparam int CPB   = 87;
  localparam int DEPTH = 4;

  logic       clk = 1'b0, reset = 1'b1, rxd = 1'b1, rd_en = 1'b0, clr_err = 1'b0;
  logic [7:0] rd_data;
  logic       rx_valid, frame_err, overrun, parity_err;

  byte unsigned exp_q[$];
  bit  exp_frame = 0, exp_ovr = 0, exp_par = 0;
  int  checks = 0, errors = 0;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .rxd(rxd), .rd_en(rd_en), .clr_err(clr_err),
    .rd_data(rd_data), .rx_valid(rx_valid), .frame_err(frame_err),
    .overrun(overrun), .parity_err(parity_err)
  );

  always #50 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: whatever the DUT will pop on the coming edge must be the model's head byte.
  always @(negedge clk) begin
    if (!reset && rd_en && rx_valid) begin
      if (exp_q.size() == 0) chk("pop_unexpected", rd_data, 256);
      else                   chk("pop_data", rd_data, exp_q.pop_front());
    end
  end

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    rxd = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  // One frame. Model decides the outcome from the frame contents and FIFO occupancy;
  // pop_at_stop raises rd_en exactly for the cycle on which the stop bit is sampled.
  task automatic send_frame(input logic [7:0] b, input bit stop, input bit bad_par,
                            input bit pop_at_stop);
    bit par_ok = 1'b1;
`ifdef UART_RX_PARITY_EN
    par_ok = !bad_par;
    if (bad_par) exp_par = 1'b1;
`endif
    if (!stop) exp_frame = 1'b1;
    if (stop && par_ok) begin
      if (exp_q.size() < DEPTH || pop_at_stop) exp_q.push_back(b);
      else exp_ovr = 1'b1;
    end
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^b) ^ bad_par);
`endif
    rxd = stop;
    if (pop_at_stop) begin
      // 2 sync flops + 1 idle-detect cycle put the sample 46 edges into each bit.
      repeat (45) @(posedge clk);
      #1 rd_en = 1'b1;
      @(posedge clk);
      #1 rd_en = 1'b0;
      repeat (CPB - 46) @(posedge clk);
      #1;
    end else begin
      repeat (CPB) @(posedge clk);
      #1;
    end
    rxd = 1'b1;
    if (!stop) idle(2 * CPB);  // let the false start from the low stop bit die out
  endtask

  task automatic check_flags(input string tag);
    chk({tag, "_frame_err"}, frame_err, exp_frame);
    chk({tag, "_overrun"}, overrun, exp_ovr);
    chk({tag, "_parity_err"}, parity_err, exp_par);
    chk({tag, "_rx_valid"}, rx_valid, exp_q.size() != 0);
  endtask

  task automatic clear_errs();
    clr_err = 1'b1;
    @(posedge clk);
    #1 clr_err = 1'b0;
    exp_frame = 0; exp_ovr = 0; exp_par = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (rx_valid && n < DEPTH + 2) begin
      rd_en = 1'b1;
      @(posedge clk);
      #1 rd_en = 1'b0;
      n++;
    end
    chk("drain_rx_valid", rx_valid, 0);
    chk("drain_rd_data", rd_data, 0);
    chk("drain_missing_bytes", exp_q.size(), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rx_valid"}, rx_valid, 0);
    chk({tag, "_rd_data"}, rd_data, 0);
    chk({tag, "_frame_err"}, frame_err, 0);
    chk({tag, "_overrun"}, overrun, 0);
    chk({tag, "_parity_err"}, parity_err, 0);
  endtask

  initial begin
    #(100 * 150000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 check_reset_vals("reset");
    reset = 1'b0;
    idle(CPB);

    // Single byte, then one pop empties the FIFO.
    send_frame(8'h3F, 1, 0, 0);
    chk("t1_rx_valid", rx_valid, 1);
    chk("t1_rd_data", rd_data, 8'h3F);
    drain();
    check_flags("t1");

    // Short low pulse is rejected as a glitch.
    rxd = 1'b0;
    repeat (20) @(posedge clk);
    #1 idle(2 * CPB);
    check_flags("glitch");

    // Framing error, clear, then a clean byte.
    send_frame(8'hA5, 0, 0, 0);
    check_flags("ferr");
    clear_errs();
    check_flags("ferr_clr");
    send_frame(8'h5A, 1, 0, 0);
    chk("t3_rd_data", rd_data, 8'h5A);
    drain();

    // Five bytes into a four-deep FIFO: last one overruns.
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1, 0, 0);
    check_flags("ovr");
    drain();
    clear_errs();

    // Full FIFO with a pop coinciding with the fifth stop sample: no overrun.
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1, 0, 0);
    send_frame(8'h05, 1, 0, 1);
    check_flags("popstop");
    drain();

    // Reset during data bit 3 flushes FIFO and flags.
    send_frame(8'h11, 1, 0, 0);
    send_frame(8'h22, 0, 0, 0);
    check_flags("pre_rst");
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    rxd = 1'b1;
    repeat (40) @(posedge clk);
    #1 reset = 1'b1;
    exp_q.delete();
    exp_frame = 0; exp_ovr = 0; exp_par = 0;
    repeat (3) @(posedge clk);
    #1 check_reset_vals("mid_rst");
    reset = 1'b0;
    idle(2 * CPB);
    check_reset_vals("post_rst");
    send_frame(8'h55, 1, 0, 0);
    chk("t6_rd_data", rd_data, 8'h55);
    drain();

`ifdef UART_RX_PARITY_EN
    send_frame(8'h3F, 1, 0, 0);
    chk("par_ok_rd_data", rd_data, 8'h3F);
    drain();
    send_frame(8'h3F, 1, 1, 0);
    check_flags("par_bad");
    clear_errs();
`endif

    // Randomized traffic with occasional bad stop/parity, reads and clears.
    for (int n = 0; n < 16; n++) begin
      logic [7:0] b = 8'($urandom);
      bit stop = ($urandom_range(0, 7) != 0);
      bit badp = 1'b0;
      bit pst  = ($urandom_range(0, 5) == 0);
`ifdef UART_RX_PARITY_EN
      badp = ($urandom_range(0, 7) == 0);
`endif
      send_frame(b, stop, badp, pst);
      check_flags("rnd");
      if ($urandom_range(0, 2) == 0) drain();
      if ($urandom_range(0, 3) == 0) begin
        clear_errs();
        check_flags("rnd_clr");
      end
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
